// File: rtl/lemming_bridge_arbiter.sv
// Single-lane bridge arbiter: round-robin grant of fixed-length crossings,
// back-to-back same-direction bursts, and a clearance gap before any reversal.
module lemming_bridge_arbiter #(
    parameter int N            = 4,
    parameter int CROSS_CYCLES = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int MAX_BURST    = 4
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] dir,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic         bridge_dir,
    output logic         busy
);
    localparam int TMAX = (CROSS_CYCLES > GAP_CYCLES) ? CROSS_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int BW   = $clog2(MAX_BURST) + 1;
    localparam int PW   = $clog2(N);
    localparam int SW   = PW + 1;

    typedef enum logic [1:0] {IDLE, CROSS, GAP} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [BW-1:0]  burst_cnt;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  cur_idx;

    logic [N-1:0]   elig;
    logic           found;
    logic [PW-1:0]  pick;
    logic [N-1:0]   pick_oh;
    logic [SW-1:0]  sum;
    logic [PW-1:0]  idx;
    logic           last;

    assign last = (state == CROSS) && (timer == '0);
    assign done = last ? grant : '0;
    assign busy = (state != IDLE);

    // While crossing, only same-direction walkers other than the current one may chain.
    always_comb begin
        if (state == IDLE) elig = req;
        else               elig = req & ~(dir ^ {N{bridge_dir}}) & ~grant;
    end

    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            idx = sum[PW-1:0];
            if (!found && elig[idx]) begin
                found        = 1'b1;
                pick         = idx;
                pick_oh      = '0;
                pick_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            grant      <= '0;
            bridge_dir <= 1'b0;
            timer      <= '0;
            burst_cnt  <= '0;
            rr_ptr     <= '0;
            cur_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick_oh;
                        bridge_dir <= dir[pick];
                        cur_idx    <= pick;
                        timer      <= TW'(CROSS_CYCLES - 1);
                        burst_cnt  <= BW'(1);
                        state      <= CROSS;
                    end
                end
                CROSS: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        rr_ptr <= (cur_idx == PW'(N - 1)) ? '0 : cur_idx + PW'(1);
                        if (found && burst_cnt < BW'(MAX_BURST)) begin
                            grant     <= pick_oh;
                            cur_idx   <= pick;
                            timer     <= TW'(CROSS_CYCLES - 1);
                            burst_cnt <= burst_cnt + BW'(1);
                        end else begin
                            grant <= '0;
                            timer <= TW'(GAP_CYCLES - 1);
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// Bench for lemming_bridge_arbiter: expected grant events are queued by each
// scenario and matched by a negedge monitor as the DUT starts each crossing.
module tb_lemming_bridge_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         areset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] dir = '0;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         bridge_dir;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   idx;
        logic d;
        int   gap;
    } gev_t;

    gev_t exp_q[$];

    int           zcnt;
    logic [N-1:0] prev_g;
    logic [N-1:0] prev_d;

    lemming_bridge_arbiter #(
        .N(N), .CROSS_CYCLES(8), .GAP_CYCLES(2), .MAX_BURST(4)
    ) dut (
        .clk(clk), .areset_n(areset_n), .req(req), .dir(dir),
        .grant(grant), .done(done), .bridge_dir(bridge_dir), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every new crossing start pops one expected event.
    always @(negedge clk) begin
        int   gi;
        gev_t e;
        if (!areset_n) begin
            zcnt   = 0;
            prev_g = '0;
            prev_d = '0;
        end else begin
            checks++;
            if ($countones(grant) > 1 || (done & ~grant) != '0) begin
                failures++;
                $display("FAIL invariant: grant=%b done=%b", grant, done);
            end
            if (grant != '0 && (prev_g == '0 || prev_d != '0)) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_event: unexpected grant idx=%0d dir=%0b", gi, bridge_dir);
                end else begin
                    e = exp_q.pop_front();
                    if (gi !== e.idx || bridge_dir !== e.d || (e.gap >= 0 && zcnt !== e.gap)) begin
                        failures++;
                        $display("FAIL grant_event: got idx=%0d dir=%0b gap=%0d, want idx=%0d dir=%0b gap=%0d",
                                 gi, bridge_dir, zcnt, e.idx, e.d, e.gap);
                    end
                end
            end
            zcnt   = (grant == '0) ? zcnt + 1 : 0;
            prev_g = grant;
            prev_d = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic d, input int gap);
        gev_t e;
        e.idx = idx; e.d = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        req = '0;
        dir = '0;
        exp_q.delete();
        tick();
        tick();
        areset_n = 1'b1;
    endtask

    // Walkers listed in drop release their request on their own done pulse.
    task automatic run_until_drained(input logic [N-1:0] drop, input int max_cyc);
        for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) begin
            tick();
            req = req & ~(done & drop);
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0 || bridge_dir !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b done=%b busy=%b bdir=%b, want all zero",
                     grant, done, busy, bridge_dir);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        dir = 4'b0100;
        push_exp(2, 1'b1, -1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0100 || bridge_dir !== 1'b1 || done !== ((c == 8) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL single_cross c%0d: grant=%b bdir=%b done=%b", c, grant, bridge_dir, done);
            end
        end
        req = '0;
        for (int c = 9; c <= 11; c++) begin
            tick();
            checks++;
            if (grant !== '0 || busy !== (c < 11)) begin
                failures++;
                $display("FAIL single_gap c%0d: grant=%b busy=%b, want grant=0 busy=%0b", c, grant, busy, c < 11);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_drain: %0d events left, want 0", exp_q.size());
        end
    endtask

    task automatic test_burst();
        do_reset();
        req = 4'b1111;
        dir = 4'b0000;
        push_exp(0, 1'b0, -1);
        push_exp(1, 1'b0, 0);
        push_exp(2, 1'b0, 0);
        push_exp(3, 1'b0, 0);
        push_exp(0, 1'b0, 3);
        run_until_drained('0, 200);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL burst_drain: %0d events left, want 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b0011;
        dir = 4'b0000;
        push_exp(0, 1'b0, -1);
        push_exp(1, 1'b0, 0);
        push_exp(0, 1'b0, 0);
        push_exp(1, 1'b0, 0);
        push_exp(0, 1'b0, 3);
        run_until_drained('0, 200);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_drain: %0d events left, want 0", exp_q.size());
        end
    endtask

    task automatic test_direction();
        do_reset();
        req = 4'b0001;
        dir = 4'b0010;
        push_exp(0, 1'b0, -1);
        tick();
        req = 4'b0111;
        push_exp(2, 1'b0, 0);
        push_exp(1, 1'b1, 3);
        run_until_drained(4'b0101, 200);
        checks++;
        if (exp_q.size() != 0 || grant !== 4'b0010 || bridge_dir !== 1'b1) begin
            failures++;
            $display("FAIL dir_reversal: left=%0d grant=%b bdir=%b, want 0 0010 1",
                     exp_q.size(), grant, bridge_dir);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        dir = 4'b0000;
        push_exp(1, 1'b0, -1);
        for (int c = 1; c <= 4; c++) tick();
        areset_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: grant=%b done=%b busy=%b, want 0 0 0", grant, done, busy);
        end
        exp_q.delete();
        req = 4'b1110;
        tick();
        areset_n = 1'b1;
        push_exp(1, 1'b0, -1);
        run_until_drained('0, 20);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_regrant: %0d events left, want 0", exp_q.size());
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b1000;
        dir = 4'b0000;
        push_exp(3, 1'b0, -1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 3) req = '0;
            checks++;
            if (grant !== 4'b1000 || done !== ((c == 8) ? 4'b1000 : 4'b0000)) begin
                failures++;
                $display("FAIL req_drop c%0d: grant=%b done=%b", c, grant, done);
            end
        end
        tick();
        req = 4'b0011;
        push_exp(0, 1'b0, 3);
        run_until_drained('0, 20);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL req_drop_next: %0d events left, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_direction();
        test_reset_mid();
        test_req_drop();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
